// File: rtl/bayes_pkg.sv
// Shared types, mode encodings and width helper for the Bayesian
// posterior accumulator / argmax block.
package bayes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCAN,
        DONE
    } state_e;

    localparam logic MODE_STOCH = 1'b0;
    localparam logic MODE_LOG   = 1'b1;

    // Score width must hold a full stochastic stream count or a sum of nobs log words.
    function automatic int acc_width(input int len_w, input int wlog, input int nobs);
        int log_w;
        log_w = wlog + $clog2(nobs);
        return (len_w > log_w) ? len_w : log_w;
    endfunction

endpackage

// File: rtl/bayes_argmax_seq.sv
// Sequential argmax: folds one (index, score) pair per step into a running best,
// lowest index winning ties, with a flag raised when the best score is matched.
module bayes_argmax_seq #(
    parameter int CLS_W = 2,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             first,
    input  logic [CLS_W-1:0] idx,
    input  logic [ACC_W-1:0] score,
    output logic [CLS_W-1:0] res_idx,
    output logic [ACC_W-1:0] res_score,
    output logic             res_tie
);

    logic [CLS_W-1:0] best_idx;
    logic [ACC_W-1:0] best_score;
    logic             best_tie;

    // res_* already include the current candidate, so the caller can capture the final answer on the last step.
    always_comb begin
        res_idx   = best_idx;
        res_score = best_score;
        res_tie   = best_tie;
        if (first) begin
            res_idx   = idx;
            res_score = score;
            res_tie   = 1'b0;
        end else if (score > best_score) begin
            res_idx   = idx;
            res_score = score;
            res_tie   = 1'b0;
        end else if (score == best_score) begin
            res_tie   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_idx   <= '0;
            best_score <= '0;
            best_tie   <= 1'b0;
        end else if (step) begin
            best_idx   <= res_idx;
            best_score <= res_score;
            best_tie   <= res_tie;
        end
    end

endmodule

// File: rtl/bayes_accum_argmax.sv
// Per-class posterior accumulator (stochastic bit counts or summed log words)
// followed by a one-class-per-cycle argmax scan with a start/done handshake.
module bayes_accum_argmax
    import bayes_pkg::*;
#(
    parameter int NCLASS = 4,
    parameter int WLOG   = 8,
    parameter int NOBS   = 4,
    parameter int LEN_W  = 10,
    parameter int CLS_W  = $clog2(NCLASS),
    parameter int ACC_W  = acc_width(LEN_W, WLOG, NOBS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   stoch_log,
    input  logic                   early_en,
    input  logic [LEN_W-1:0]       stream_len,
    input  logic [ACC_W-1:0]       thresh,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCLASS-1:0]      stoch_bits,
    input  logic [NCLASS*WLOG-1:0] log_words,
    output logic                   busy,
    output logic                   done,
    output logic [CLS_W-1:0]       winner,
    output logic [ACC_W-1:0]       winner_score,
    output logic                   tie,
    output logic                   early_hit
);

    localparam int CNT_W = (LEN_W > $clog2(NOBS + 1)) ? LEN_W : $clog2(NOBS + 1);

    state_e           state, state_nxt;
    logic             mode_q, early_q, hit_q;
    logic [LEN_W-1:0] len_q;
    logic [ACC_W-1:0] thresh_q;
    logic [ACC_W-1:0] acc     [NCLASS];
    logic [ACC_W-1:0] acc_nxt [NCLASS];
    logic [CNT_W-1:0] beat_cnt, target;
    logic [CLS_W-1:0] scan_idx;
    logic             accept_start, beat, last_beat, thresh_hit, accum_exit, scan_last;
    logic [CLS_W-1:0] res_idx;
    logic [ACC_W-1:0] res_score;
    logic             res_tie;

    assign in_ready     = (state == ACCUM);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign accept_start = (state == IDLE) && start && !abort;
    assign beat         = in_valid && in_ready;

    // A programmed stream length of zero behaves as a single beat.
    assign target = (mode_q == MODE_LOG) ? CNT_W'(NOBS)
                  : (len_q == '0)        ? CNT_W'(1)
                  :                        CNT_W'(len_q);

    assign last_beat  = ((beat_cnt + CNT_W'(1)) == target);
    assign accum_exit = beat && (last_beat || thresh_hit);
    assign scan_last  = (scan_idx == CLS_W'(NCLASS - 1));

    always_comb begin
        thresh_hit = 1'b0;
        for (int c = 0; c < NCLASS; c++) begin
            acc_nxt[c] = acc[c] + ((mode_q == MODE_LOG) ? ACC_W'(log_words[c*WLOG +: WLOG])
                                                        : ACC_W'(stoch_bits[c]));
            if ((mode_q == MODE_STOCH) && early_q && (acc_nxt[c] >= thresh_q)) begin
                thresh_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_start) state_nxt = ACCUM;
            ACCUM: begin
                if (abort)           state_nxt = IDLE;
                else if (accum_exit) state_nxt = SCAN;
            end
            SCAN: begin
                if (abort)           state_nxt = IDLE;
                else if (scan_last)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers only change at the end of a completed scan, so an abort leaves the previous answer intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_STOCH;
            early_q      <= 1'b0;
            hit_q        <= 1'b0;
            len_q        <= '0;
            thresh_q     <= '0;
            beat_cnt     <= '0;
            scan_idx     <= '0;
            winner       <= '0;
            winner_score <= '0;
            tie          <= 1'b0;
            early_hit    <= 1'b0;
            for (int c = 0; c < NCLASS; c++) acc[c] <= '0;
        end else begin
            if (accept_start) begin
                mode_q   <= stoch_log;
                early_q  <= early_en;
                len_q    <= stream_len;
                thresh_q <= thresh;
                hit_q    <= 1'b0;
                beat_cnt <= '0;
                scan_idx <= '0;
                for (int c = 0; c < NCLASS; c++) acc[c] <= '0;
            end else if ((state == ACCUM) && !abort && beat) begin
                for (int c = 0; c < NCLASS; c++) acc[c] <= acc_nxt[c];
                beat_cnt <= beat_cnt + CNT_W'(1);
                if (accum_exit) begin
                    scan_idx <= '0;
                    hit_q    <= thresh_hit;
                end
            end else if ((state == SCAN) && !abort) begin
                scan_idx <= scan_idx + CLS_W'(1);
                if (scan_last) begin
                    winner       <= res_idx;
                    winner_score <= res_score;
                    tie          <= res_tie;
                    early_hit    <= hit_q;
                end
            end
        end
    end

    bayes_argmax_seq #(
        .CLS_W (CLS_W),
        .ACC_W (ACC_W)
    ) u_argmax (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      ((state == SCAN) && !abort),
        .first     (scan_idx == '0),
        .idx       (scan_idx),
        .score     (acc[scan_idx]),
        .res_idx   (res_idx),
        .res_score (res_score),
        .res_tie   (res_tie)
    );

endmodule

// File: tb/tb_bayes_accum_argmax.sv
// Directed bench for bayes_accum_argmax: a behavioural score model feeds a
// scoreboard of expected results that is drained on each done pulse.
module tb_bayes_accum_argmax;

    localparam int NCLASS = 4;
    localparam int WLOG   = 8;
    localparam int NOBS   = 4;
    localparam int LEN_W  = 10;
    localparam int CLS_W  = 2;
    localparam int ACC_W  = 10;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic                   stoch_log = 1'b0;
    logic                   early_en = 1'b0;
    logic [LEN_W-1:0]       stream_len = '0;
    logic [ACC_W-1:0]       thresh = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [NCLASS-1:0]      stoch_bits = '0;
    logic [NCLASS*WLOG-1:0] log_words = '0;
    logic                   busy;
    logic                   done;
    logic [CLS_W-1:0]       winner;
    logic [ACC_W-1:0]       winner_score;
    logic                   tie;
    logic                   early_hit;

    typedef struct {
        int winner;
        int score;
        bit tie;
        bit early;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   model_acc[NCLASS];
    bit   model_mode;
    int   checks = 0;
    int   errors = 0;

    bayes_accum_argmax #(
        .NCLASS (NCLASS),
        .WLOG   (WLOG),
        .NOBS   (NOBS),
        .LEN_W  (LEN_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .stoch_log    (stoch_log),
        .early_en     (early_en),
        .stream_len   (stream_len),
        .thresh       (thresh),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stoch_bits   (stoch_bits),
        .log_words    (log_words),
        .busy         (busy),
        .done         (done),
        .winner       (winner),
        .winner_score (winner_score),
        .tie          (tie),
        .early_hit    (early_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the end of the directed sequence");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic startRun(input bit mode, input bit early, input int len, input int th);
        @(negedge clk);
        start      = 1'b1;
        stoch_log  = mode;
        early_en   = early;
        stream_len = LEN_W'(len);
        thresh     = ACC_W'(th);
        model_mode = mode;
        for (int c = 0; c < NCLASS; c++) model_acc[c] = 0;
    endtask

    // One cycle in ACCUM: drives a beat (or a bubble) and folds accepted data into the model.
    task automatic applyStimulus(input bit valid, input logic [3:0] bits,
                                 input int w0, input int w1, input int w2, input int w3);
        @(negedge clk);
        start = 1'b0;
        checkOutput("in_ready_accum", in_ready, 1);
        in_valid   = valid;
        stoch_bits = bits;
        log_words  = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
        if (valid) begin
            if (model_mode) begin
                model_acc[0] += w0; model_acc[1] += w1;
                model_acc[2] += w2; model_acc[3] += w3;
            end else begin
                for (int c = 0; c < NCLASS; c++) model_acc[c] += int'(bits[c]);
            end
        end
    endtask

    // Argmax written as max-then-first-match, independent of the scan order in hardware.
    task automatic pushExpect(input bit early);
        exp_t e;
        int   mx;
        int   n;
        mx = 0;
        n  = 0;
        for (int c = 0; c < NCLASS; c++) if (model_acc[c] > mx) mx = model_acc[c];
        e.winner = -1;
        for (int c = 0; c < NCLASS; c++) begin
            if (model_acc[c] == mx) begin
                n++;
                if (e.winner < 0) e.winner = c;
            end
        end
        e.score = mx;
        e.tie   = (n > 1);
        e.early = early;
        sb.push_back(e);
        last_exp = e;
    endtask

    task automatic waitDone(input string tag, input int already);
        int   n;
        bit   seen;
        exp_t e;
        n    = already;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
            if (done) seen = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, seen, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                checkOutput({tag, "_latency"}, n, NCLASS + 1);
                checkOutput({tag, "_winner"}, winner, e.winner);
                checkOutput({tag, "_score"}, winner_score, e.score);
                checkOutput({tag, "_tie"}, tie, e.tie);
                checkOutput({tag, "_early_hit"}, early_hit, e.early);
                @(negedge clk);
                checkOutput({tag, "_done_pulse"}, done, 0);
                checkOutput({tag, "_idle"}, busy, 0);
            end
        end else begin
            checkOutput({tag, "_scoreboard"}, 0, 1);
        end
    endtask

    initial begin
        logic [3:0] pat [8];
        bit         saw_done;
        pat = '{4'b1001, 4'b0011, 4'b1010, 4'b0001, 4'b1000, 4'b0101, 4'b1001, 4'b0010};

        #2;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_winner", winner, 0);
        checkOutput("rst_score", winner_score, 0);
        checkOutput("rst_tie", tie, 0);
        checkOutput("rst_early", early_hit, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] stochastic tie, stream_len=8");
        startRun(1'b0, 1'b0, 8, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'b0110, 0, 0, 0, 0);
        pushExpect(1'b0);
        @(negedge clk);
        stoch_bits = 4'b0100;
        checkOutput("stoch_in_ready_after_last", in_ready, 0);
        waitDone("stoch", 1);

        $display("[TB] log mode, NOBS beats");
        startRun(1'b1, 1'b0, 0, 0);
        applyStimulus(1'b1, 4'b0000, 10, 20, 30, 40);
        applyStimulus(1'b1, 4'b0000, 200, 0, 0, 0);
        applyStimulus(1'b1, 4'b0000, 0, 0, 0, 0);
        applyStimulus(1'b1, 4'b0000, 0, 0, 0, 255);
        pushExpect(1'b0);
        waitDone("log", 0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_idle", busy, 0);

        $display("[TB] early stop at threshold");
        startRun(1'b0, 1'b1, 100, 5);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0100, 0, 0, 0, 0);
        pushExpect(1'b1);
        waitDone("early", 0);

        $display("[TB] stalled stochastic stream");
        startRun(1'b0, 1'b0, 8, 0);
        for (int i = 0; i < 15; i++) applyStimulus((i % 2) == 0, pat[i / 2], 0, 0, 0, 0);
        pushExpect(1'b0);
        waitDone("stall", 0);

        $display("[TB] abort on third log beat");
        startRun(1'b1, 1'b0, 0, 0);
        applyStimulus(1'b1, 4'b0000, 255, 255, 255, 255);
        applyStimulus(1'b1, 4'b0000, 255, 255, 255, 255);
        @(negedge clk);
        in_valid  = 1'b1;
        log_words = {8'd255, 8'd255, 8'd255, 8'd255};
        abort     = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort_busy", busy, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", saw_done, 0);
        checkOutput("abort_keep_winner", winner, last_exp.winner);
        checkOutput("abort_keep_score", winner_score, last_exp.score);
        checkOutput("abort_keep_tie", tie, last_exp.tie);

        $display("[TB] reset during scan, then zero stream length");
        startRun(1'b0, 1'b0, 2, 0);
        applyStimulus(1'b1, 4'b0001, 0, 0, 0, 0);
        applyStimulus(1'b1, 4'b0001, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("scan_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_winner", winner, 0);
        checkOutput("midrst_score", winner_score, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        startRun(1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 4'b0010, 0, 0, 0, 0);
        pushExpect(1'b0);
        waitDone("len0", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bayes_accum_argmax.md
Name: bayes_accum_argmax

Overview:
- Parametrised per-class posterior accumulator and decision unit; sits downstream of the likelihood array and replaces the fixed 4-class bit/word output path.
- Stochastic mode: counts the 1s on each class's ANDed bitstream over a programmable stream length, with optional early stop at a threshold.
- Log mode: sums NOBS unsigned log-likelihood words per class.
- After accumulation, a sequential argmax scan returns the winning class, its score and a tie flag, signalled by a start/done handshake.

Parameters:
- NCLASS, 4, number of class channels (≥2).
- WLOG, 8, width of one log-likelihood word.
- NOBS, 4, observations summed per inference in log mode (≥1).
- LEN_W, 10, width of the stream-length setting; max stream length is 2**LEN_W-1.
- CLS_W, $clog2(NCLASS), class index width (derived).
- ACC_W, max(LEN_W, WLOG+$clog2(NOBS)), score width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin an inference; sampled only in IDLE.
- abort  in  1  return to IDLE, no done pulse.
- stoch_log  in  1  0 = stochastic, 1 = logarithmic; latched at start.
- early_en  in  1  enable the stochastic early stop; latched at start.
- stream_len  in  LEN_W  number of stochastic beats; latched at start; 0 is treated as 1.
- thresh  in  ACC_W  early-stop count; latched at start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  high in ACCUM; a beat transfers when in_valid && in_ready.
- stoch_bits  in  NCLASS  one ANDed stochastic bit per class.
- log_words  in  NCLASS*WLOG  class c occupies bits [c*WLOG +: WLOG].
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- winner  out  CLS_W  argmax class index.
- winner_score  out  ACC_W  score of the winner.
- tie  out  1  another class has a score equal to the winner's.
- early_hit  out  1  the inference ended by the threshold.

Behaviour:
- Reset: FSM goes to IDLE; all outputs, accumulators and counters are 0; in_ready=0.
- IDLE: on start, latch the mode and settings, clear the accumulators and beat counter, go to ACCUM next cycle. A start in any other state is ignored.
- ACCUM, per accepted beat:
  - Stochastic: acc[c] += stoch_bits[c].
  - Log: acc[c] += log_words[c], zero-extended.
  - Beat counter increments.
  - Exit after the beat that makes the count equal stream_len (stochastic) or NOBS (log).
  - Stochastic with early_en: also exit after the beat in which any acc[c] (post-update) ≥ thresh; early_hit is then set at done.
- Arithmetic is non-saturating; widths are sized so overflow cannot occur.
- in_valid low stalls without penalty.
- SCAN: NCLASS cycles. Cycle k compares acc[k] with the running best.
  - Strictly greater replaces the best, so the lowest index wins a tie.
  - Equal to the best sets tie; a new strict best clears tie.
  - Index 0 initialises the best.
- DONE: one cycle. Drive done=1; winner, winner_score, tie and early_hit are registered and hold until the next start, then go to IDLE.
- Latency: done asserts NCLASS+1 cycles after the last accepted beat.
- abort in ACCUM or SCAN: go to IDLE next cycle. No done pulse; previous results are retained. abort has priority over the beat and exit conditions in the same cycle.
- Simultaneous start and abort in IDLE: abort wins (stay in IDLE).
- Reset mid-operation: immediate return to the reset state, with results cleared.

Decomposition:
- Shared package bayes_pkg holds:
  - typedef state_e {IDLE, ACCUM, SCAN, DONE};
  - the mode constants MODE_STOCH=0 and MODE_LOG=1;
  - a function computing ACC_W.
- One natural sub-module: bayes_argmax_seq, the sequential scan holding the running best, index and tie. It is instantiated once.

Test Plan:
- Stochastic, NCLASS=4, stream_len=8, early_en=0; drive stoch_bits=4'b0110 for 8 beats, then 4'b0100 → acc={0,8,8,0}; winner=1, score=8, tie=1; done 5 cycles after the last beat.
- Log mode, NOBS=4; per beat log_words class0..3={10,20,30,40}, {200,0,0,0}, {0,0,0,0}, {0,0,0,255} → scores {210,20,30,295}; winner=3, score=295, tie=0.
- Early stop: stream_len=100, thresh=5, stoch_bits=4'b0100 on every beat → exit after beat 5; winner=2, score=5, early_hit=1.
- in_valid toggling 1010… over 8 stochastic beats → same result as back-to-back; in_ready stays high throughout ACCUM.
- abort asserted on the 3rd beat of a log inference → busy=0 the next cycle, no done, and the results of the prior run are unchanged.
- rst_n dropped during SCAN → outputs 0 immediately; start after release runs a clean inference; stream_len=0 ends after 1 beat.
